// File: rtl/rs15_11_pkg.sv
// Shared constants for the RS(15,11) receive path: code dimensions, framer
// FSM state encoding and bit-counter width.
package rs15_11_pkg;

  localparam int unsigned RS_N      = 15;
  localparam int unsigned RS_K      = 11;
  localparam int unsigned RS_PARITY = 4;

  // Enough bits to count 0..RS_N-1 channel bits of a frame.
  localparam int unsigned BIT_CNT_W = $clog2(RS_N);

  // Framer FSM encoding, kept as plain constants for legacy compatibility.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/rs15_11_cw_buf.sv
// One-deep valid/ready holding register for assembled codewords.
// A completed frame is loaded when the buffer is empty or being drained in
// the same cycle; otherwise it is dropped and overrun pulses for one cycle.
// With RS_RX_STATS_EN defined, saturating load/drop counters are included.
module rs15_11_cw_buf
  import rs15_11_pkg::*;
#(
  parameter int unsigned CW_W = RS_N
`ifdef RS_RX_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [CW_W-1:0] data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [CW_W-1:0] data_o,
  output logic            overrun_o
`ifdef RS_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
`endif
);

  logic            valid_q, valid_d;
  logic [CW_W-1:0] data_q, data_d;
  logic            overrun_q, overrun_d;
  logic            loaded;

  // Load/accept/drop decision for the holding register.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    loaded    = load_i & (~valid_q | ready_i);
    overrun_d = load_i & ~loaded;
    if (loaded) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

`ifdef RS_RX_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;

  // Saturating statistics: buffer loads and overrun drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (loaded && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (overrun_d && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: rtl/rs15_11_rx_framer.sv
// Bit-serial RS(15,11) receive framer. Collects 15 channel bits MSB first
// (frame start marked by ser_sof) and hands complete codewords to a 1-deep
// valid/ready buffer feeding the decoder. Flags mid-frame sof (sync_err)
// and frames dropped on a full buffer (overrun).
// Optional: RS_RX_STATS_EN adds frame_cnt/drop_cnt statistics ports.
module rs15_11_rx_framer
  import rs15_11_pkg::*;
#(
  parameter int unsigned CW_W = RS_N
`ifdef RS_RX_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ser_valid,
  input  logic            ser_bit,
  input  logic            ser_sof,
  output logic            cw_valid,
  input  logic            cw_ready,
  output logic [CW_W-1:0] codeword_out,
  output logic            busy,
  output logic            overrun,
  output logic            sync_err
`ifdef RS_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  logic [0:0]           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  // The first bit only reaches position CW_W-1 as the final bit arrives,
  // so the register holds just the CW_W-1 bits collected so far.
  logic [CW_W-2:0]      shreg_q, shreg_d;
  logic                 sync_err_q, sync_err_d;
  logic                 frame_done;
  logic [CW_W-1:0]      frame_data;

  // Framer FSM: sof detection, bit shifting and frame completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    sync_err_d = 1'b0;
    frame_done = 1'b0;
    frame_data = {shreg_q, ser_bit};
    if (ser_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ser_sof) begin
            shreg_d = {{(CW_W-2){1'b0}}, ser_bit};
            cnt_d   = BIT_CNT_W'(1);
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ser_sof) begin
            sync_err_d = 1'b1;
            shreg_d    = {{(CW_W-2){1'b0}}, ser_bit};
            cnt_d      = BIT_CNT_W'(1);
          end else begin
            shreg_d = {shreg_q[CW_W-3:0], ser_bit};
            if (cnt_q == BIT_CNT_W'(CW_W-1)) begin
              frame_done = 1'b1;
              cnt_d      = '0;
              state_d    = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Framer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign sync_err = sync_err_q;

  rs15_11_cw_buf #(
    .CW_W (CW_W)
`ifdef RS_RX_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_cw_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (frame_done),
    .data_i     (frame_data),
    .ready_i    (cw_ready),
    .valid_o    (cw_valid),
    .data_o     (codeword_out),
    .overrun_o  (overrun)
`ifdef RS_RX_STATS_EN
    ,
    .frame_cnt_o(frame_cnt),
    .drop_cnt_o (drop_cnt)
`endif
  );

endmodule

// File: tb/tb_rs15_11_rx_framer.sv
// Self-checking bench for rs15_11_rx_framer: expected codewords are queued as
// frames are driven and compared when the DUT hands them over.
module tb_rs15_11_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_valid, ser_bit, ser_sof;
  logic        cw_valid, cw_ready;
  logic [14:0] codeword_out;
  logic        busy, overrun, sync_err;
`ifdef RS_RX_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] sb_q[$];

  always #5 clk = ~clk;

  rs15_11_rx_framer #(
    .CW_W(15)
`ifdef RS_RX_STATS_EN
    ,
    .CNT_W(16)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_valid   (ser_valid),
    .ser_bit     (ser_bit),
    .ser_sof     (ser_sof),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .codeword_out(codeword_out),
    .busy        (busy),
    .overrun     (overrun),
    .sync_err    (sync_err)
`ifdef RS_RX_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: a codeword seen with valid&ready is taken at the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cw_valid === 1'b1 && cw_ready === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_cw", 32'(cw_valid), 32'd0);
      else check("cw_data", 32'(codeword_out), 32'(sb_q.pop_front()));
    end
  end

  task automatic send_bit(input logic b, input logic sof);
    ser_valid = 1'b1;
    ser_bit   = b;
    ser_sof   = sof;
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
    ser_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic [14:0] cw, input bit gaps, input bit deliver,
                            input logic exp_sync);
    if (deliver) sb_q.push_back(cw);
    for (int i = 14; i >= 0; i--) begin
      send_bit(cw[i], i == 14);
      @(negedge clk);
      if (i == 14) check("sync_err", 32'(sync_err), 32'(exp_sync));
      if (i == 13) check("sync_err_clr", 32'(sync_err), 32'd0);
      if (i > 0) begin
        check("busy", 32'(busy), 32'd1);
      end else begin
        check("busy_end", 32'(busy), 32'd0);
        if (deliver) check("cw_valid_lat", 32'(cw_valid), 32'd1);
      end
      if (gaps && i > 0) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        check("busy_gap", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic send_partial(input logic [14:0] cw, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      send_bit(cw[14-k], k == 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n     = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_sof   = 1'b0;
    cw_ready  = 1'b1;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cw_valid", 32'(cw_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cw", 32'(codeword_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
`ifdef RS_RX_STATS_EN
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Contiguous frame, consumer ready.
    send_frame(15'h2AB5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_valid_drop", 32'(cw_valid), 32'd0);
    check("t2_cw_hold", 32'(codeword_out), 32'h2AB5);
`ifdef RS_RX_STATS_EN
    check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
`endif

    // Same frame with ser_valid gaps.
    send_frame(15'h2AB5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("t3_valid_drop", 32'(cw_valid), 32'd0);

    // Back-to-back frames with consumer stalled.
    #1;
    cw_ready = 1'b0;
    send_frame(15'h0001, 1'b0, 1'b1, 1'b0);
    check("t4_no_ovr1", 32'(overrun), 32'd0);
    send_frame(15'h7FFE, 1'b0, 1'b0, 1'b0);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_valid", 32'(cw_valid), 32'd1);
    check("t4_cw_hold", 32'(codeword_out), 32'h0001);
`ifdef RS_RX_STATS_EN
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd3);
`endif
    @(negedge clk);
    check("t4_overrun_clr", 32'(overrun), 32'd0);
    check("t4_still_valid", 32'(cw_valid), 32'd1);
    @(posedge clk);
    #1;
    cw_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_accepted", 32'(cw_valid), 32'd0);

    // Sof mid-frame restarts collection.
    send_partial(15'h7FFF, 7);
    send_frame(15'h1234, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_valid_drop", 32'(cw_valid), 32'd0);

    // Reset mid-frame, then orphan bits without sof.
    send_partial(15'h6A6A, 9);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_cw_rst", 32'(codeword_out), 32'd0);
    for (int j = 0; j < 6; j++) begin
      send_bit(1'(j & 1), 1'b0);
      @(negedge clk);
      check("t6_busy_orphan", 32'(busy), 32'd0);
      check("t6_valid_orphan", 32'(cw_valid), 32'd0);
    end
    send_frame(15'h5A3C, 1'b0, 1'b1, 1'b0);
`ifdef RS_RX_STATS_EN
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
